writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter XADDR, default 5, register-address width.
REQ-003 SHALL have port i_clk  input  1  CPU clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port i_valid  input  1  upstream (memory stage) presents an instruction.
REQ-006 SHALL have port i_opcode  input  7  instruction opcode.
REQ-007 SHALL have port i_funct3  input  3  load width/sign select.
REQ-008 SHALL have port i_rd_addr  input  XADDR  destination register.
REQ-009 SHALL have port i_alu_result  input  XLEN  ALU result or load/store address.
REQ-010 SHALL have port i_pc  input  XLEN  instruction PC.
REQ-011 SHALL have port i_write_enable  input  1  register write requested by decode.
REQ-012 SHALL have port i_dmem_rvalid  input  1  data-memory read response valid.
REQ-013 SHALL have port i_dmem_rdata  input  XLEN  aligned 32-bit data-memory word.
REQ-014 SHALL have port o_stall  output  1  upstream holds all i_* stable while high.
REQ-015 SHALL have port or_rd_addr  output  XADDR  register-file write address (to decode).
REQ-016 SHALL have port or_rd_data  output  XLEN  register-file write data.
REQ-017 SHALL have port or_wr_en  output  1  register-file write enable.
REQ-018 SHALL have port or_instret  output  64  retired-instruction count.

Function
REQ-019 SHALL implement states IDLE and WAIT_LOAD; o_stall SHALL equal (state == WAIT_LOAD), combinationally.
REQ-020 In IDLE, i_valid with a recognised opcode (LUI, AUIPC, JAL, JALR, B, L, S, R, I) SHALL be accepted; any other opcode, including 0 (bubble), SHALL cause no write and no retire.
REQ-021 Accepted non-load SHALL update or_* on the next edge: single-cycle latency; state stays IDLE.
REQ-022 Result select: JAL/JALR -> i_pc+4 (mod 2^XLEN); LUI/AUIPC/R/I -> i_alu_result; B/S -> no write.
REQ-023 Accepted load SHALL capture rd, funct3, i_alu_result[1:0], i_write_enable, and go WAIT_LOAD; no output change that edge.
REQ-024 In WAIT_LOAD, i_valid SHALL be ignored; on i_dmem_rvalid, the formatted load SHALL be written on that edge, and the state SHALL return to IDLE.
REQ-025 Load format (off=captured addr[1:0]): 000 LB sign-extended byte off; 001 LH sign-extended half at off[1]; 010 LW whole word; 100 LBU zero-extended byte; 101 LHU zero-extended half; other funct3 -> whole word.
REQ-026 or_wr_en SHALL be 1 for exactly one cycle per completing instruction when the write is requested, i_write_enable (or captured copy) = 1, and rd != 0; otherwise 0.
REQ-027 or_rd_addr/or_rd_data SHALL hold their last values when or_wr_en = 0.
REQ-028 or_instret SHALL increment by 1 on each completion (recognised non-load accept, or load response), regardless of rd or write enable; it SHALL wrap from 2^64-1 to 0.
REQ-029 i_dmem_rvalid in IDLE SHALL be ignored.
REQ-030 Load responses SHALL have no latency bound; WAIT_LOAD SHALL persist until i_dmem_rvalid.

Reset
REQ-031 On i_rst_n low (any time, asynchronously): state IDLE, o_stall 0, or_rd_addr 0, or_rd_data 0, or_wr_en 0, or_instret 0.
REQ-032 Reset during WAIT_LOAD SHALL discard the pending load; a later i_dmem_rvalid in IDLE SHALL be ignored.

Verification
REQ-033 ADDI: i_opcode I, rd=5, i_alu_result=0x00000010, we=1 -> next cycle or_wr_en=1, rd=5, data=0x10, instret=1.
REQ-034 JAL: rd=1, i_pc=0x00000100 -> data=0x00000104; JAL with rd=0 -> or_wr_en=0, instret increments.
REQ-035 LB: addr[1:0]=3, 3-cycle response, rdata=0x80FFFFFF -> o_stall high 3 cycles, then data=0xFFFFFF80; LBU same -> 0x00000080; LH off=2, rdata=0x1234ABCD -> 0x00001234.
REQ-036 During WAIT_LOAD, a held ADD on i_valid -> not accepted until the cycle after the load writes; then written once.
REQ-037 Reset asserted mid-WAIT_LOAD, later rvalid=1 -> no write, instret=0, o_stall=0.
REQ-038 Store, branch, opcode 0 -> or_wr_en stays 0; instret +1, +1, +0 respectively.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: selects the register-file write value, formats load responses
// and counts retired instructions. A load holds the pipeline until its data arrives.
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int XADDR = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [6:0]       i_opcode,
  input  logic [2:0]       i_funct3,
  input  logic [XADDR-1:0] i_rd_addr,
  input  logic [XLEN-1:0]  i_alu_result,
  input  logic [XLEN-1:0]  i_pc,
  input  logic             i_write_enable,
  input  logic             i_dmem_rvalid,
  input  logic [XLEN-1:0]  i_dmem_rdata,
  output logic             o_stall,
  output logic [XADDR-1:0] or_rd_addr,
  output logic [XLEN-1:0]  or_rd_data,
  output logic             or_wr_en,
  output logic [63:0]      or_instret
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_LOAD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [XADDR-1:0] ld_rd_q, ld_rd_d;
  logic [2:0]       ld_funct3_q, ld_funct3_d;
  logic [1:0]       ld_off_q, ld_off_d;
  logic             ld_we_q, ld_we_d;
  logic [XADDR-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]  rd_data_q, rd_data_d;
  logic             wr_en_q, wr_en_d;
  logic [63:0]      instret_q, instret_d;

  logic recognised;
  logic writes_rd;
  logic is_link;

  // Extract and extend the addressed byte/half from the aligned response word.
  function automatic logic [XLEN-1:0] format_load(input logic [2:0] f3,
                                                   input logic [1:0] off,
                                                   input logic [XLEN-1:0] word);
    logic [XLEN-1:0] shifted;
    logic [7:0]      b;
    logic [15:0]     h;
    shifted = word >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  format_load = {{(XLEN-8){b[7]}}, b};
      3'b001:  format_load = {{(XLEN-16){h[15]}}, h};
      3'b100:  format_load = {{(XLEN-8){1'b0}}, b};
      3'b101:  format_load = {{(XLEN-16){1'b0}}, h};
      default: format_load = word;
    endcase
  endfunction

  always_comb begin
    recognised = 1'b0;
    writes_rd  = 1'b0;
    is_link    = 1'b0;
    case (i_opcode)
      OP_LUI, OP_AUIPC, OP_R, OP_I: begin
        recognised = 1'b1;
        writes_rd  = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        recognised = 1'b1;
        writes_rd  = 1'b1;
        is_link    = 1'b1;
      end
      OP_B, OP_S, OP_L: recognised = 1'b1;
      default: recognised = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ld_rd_d     = ld_rd_q;
    ld_funct3_d = ld_funct3_q;
    ld_off_d    = ld_off_q;
    ld_we_d     = ld_we_q;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    wr_en_d     = 1'b0;
    instret_d   = instret_q;

    if (state_q == IDLE) begin
      if (i_valid && recognised) begin
        if (i_opcode == OP_L) begin
          ld_rd_d     = i_rd_addr;
          ld_funct3_d = i_funct3;
          ld_off_d    = i_alu_result[1:0];
          ld_we_d     = i_write_enable;
          state_d     = WAIT_LOAD;
        end else begin
          instret_d = instret_q + 64'd1;
          if (writes_rd && i_write_enable && (i_rd_addr != '0)) begin
            wr_en_d   = 1'b1;
            rd_addr_d = i_rd_addr;
            rd_data_d = is_link ? (i_pc + XLEN'(4)) : i_alu_result;
          end
        end
      end
    end else begin
      // New instructions are held off upstream by o_stall until the load lands.
      if (i_dmem_rvalid) begin
        state_d   = IDLE;
        instret_d = instret_q + 64'd1;
        if (ld_we_q && (ld_rd_q != '0)) begin
          wr_en_d   = 1'b1;
          rd_addr_d = ld_rd_q;
          rd_data_d = format_load(ld_funct3_q, ld_off_q, i_dmem_rdata);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      ld_rd_q     <= '0;
      ld_funct3_q <= '0;
      ld_off_q    <= '0;
      ld_we_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      wr_en_q     <= 1'b0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      ld_rd_q     <= ld_rd_d;
      ld_funct3_q <= ld_funct3_d;
      ld_off_q    <= ld_off_d;
      ld_we_q     <= ld_we_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      wr_en_q     <= wr_en_d;
      instret_q   <= instret_d;
    end
  end

  assign o_stall    = (state_q == WAIT_LOAD);
  assign or_rd_addr = rd_addr_q;
  assign or_rd_data = rd_data_q;
  assign or_wr_en   = wr_en_q;
  assign or_instret = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus a randomized run, all checked
// against a transaction-level reference model of the stage.
module tb_writeback_stage;
  localparam int XLEN  = 32;
  localparam int XADDR = 5;

  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_B     = 7'h63;
  localparam logic [6:0] OP_L     = 7'h03;
  localparam logic [6:0] OP_S     = 7'h23;
  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_valid;
  logic [6:0]       i_opcode;
  logic [2:0]       i_funct3;
  logic [XADDR-1:0] i_rd_addr;
  logic [XLEN-1:0]  i_alu_result;
  logic [XLEN-1:0]  i_pc;
  logic             i_write_enable;
  logic             i_dmem_rvalid;
  logic [XLEN-1:0]  i_dmem_rdata;
  logic             o_stall;
  logic [XADDR-1:0] or_rd_addr;
  logic [XLEN-1:0]  or_rd_data;
  logic             or_wr_en;
  logic [63:0]      or_instret;

  always #5 i_clk = ~i_clk;

  writeback_stage #(.XLEN(XLEN), .XADDR(XADDR)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_opcode(i_opcode),
    .i_funct3(i_funct3), .i_rd_addr(i_rd_addr), .i_alu_result(i_alu_result),
    .i_pc(i_pc), .i_write_enable(i_write_enable), .i_dmem_rvalid(i_dmem_rvalid),
    .i_dmem_rdata(i_dmem_rdata), .o_stall(o_stall), .or_rd_addr(or_rd_addr),
    .or_rd_data(or_rd_data), .or_wr_en(or_wr_en), .or_instret(or_instret)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one pending-load record plus the architecturally visible outputs.
  bit          m_wait = 0;
  logic [4:0]  m_ld_rd = '0;
  logic [2:0]  m_ld_f3 = '0;
  logic [1:0]  m_ld_off = '0;
  bit          m_ld_we = 0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  bit          m_wen = 0;
  logic [63:0] m_instret = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] b;
    logic [31:0] h;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  // 0 = unrecognised, 1 = writes alu result, 2 = writes link, 3 = no write, 4 = load
  function automatic int kind_of(input logic [6:0] op);
    if (op == OP_LUI || op == OP_AUIPC || op == OP_R || op == OP_I) return 1;
    if (op == OP_JAL || op == OP_JALR) return 2;
    if (op == OP_B || op == OP_S) return 3;
    if (op == OP_L) return 4;
    return 0;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_addr = '0; m_data = '0; m_wen = 0; m_instret = '0;
  endtask

  task automatic model_edge();
    int k;
    m_wen = 0;
    if (m_wait) begin
      if (i_dmem_rvalid) begin
        m_wait = 0;
        m_instret = m_instret + 1;
        if (m_ld_we && m_ld_rd != 0) begin
          m_wen = 1; m_addr = m_ld_rd; m_data = ref_load(m_ld_f3, m_ld_off, i_dmem_rdata);
        end
      end
    end else if (i_valid) begin
      k = kind_of(i_opcode);
      if (k == 4) begin
        m_wait = 1; m_ld_rd = i_rd_addr; m_ld_f3 = i_funct3;
        m_ld_off = i_alu_result[1:0]; m_ld_we = i_write_enable;
      end else if (k != 0) begin
        m_instret = m_instret + 1;
        if (k != 3 && i_write_enable && i_rd_addr != 0) begin
          m_wen = 1; m_addr = i_rd_addr;
          m_data = (k == 2) ? i_pc + 32'd4 : i_alu_result;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_stall"}, 64'(o_stall), 64'(m_wait));
    check({tag, "_wen"}, 64'(or_wr_en), 64'(m_wen));
    check({tag, "_addr"}, 64'(or_rd_addr), 64'(m_addr));
    check({tag, "_data"}, 64'(or_rd_data), 64'(m_data));
    check({tag, "_instret"}, or_instret, m_instret);
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge i_clk);
    #1;
    compare_all(tag);
  endtask

  task automatic present(input bit v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] pc, input bit we);
    i_valid = v; i_opcode = op; i_funct3 = f3; i_rd_addr = rd;
    i_alu_result = alu; i_pc = pc; i_write_enable = we;
  endtask

  // Issue a load, respond after 'delay' stalled cycles, return how many cycles stalled.
  task automatic do_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                         input int delay, input logic [31:0] rdata, output int stalls);
    stalls = 0;
    present(1, OP_L, f3, rd, addr, 32'h0, 1);
    tick("ld_accept");
    if (o_stall) stalls++;
    present(0, 7'h00, 3'd0, 5'd0, 32'h0, 32'h0, 0);
    for (int i = 1; i < delay; i++) begin
      tick("ld_wait");
      if (o_stall) stalls++;
    end
    i_dmem_rvalid = 1; i_dmem_rdata = rdata;
    tick("ld_resp");
    i_dmem_rvalid = 0;
    $display("load f3=%0d rd=%0d addr=%08h rdata=%08h -> data=%08h wen=%0d", f3, rd, addr,
             rdata, or_rd_data, or_wr_en);
  endtask

  initial begin
    logic [6:0] ops [12];
    int stalls;
    int rd9_writes;
    bit was_wait;
    ops = '{OP_L, OP_L, OP_I, OP_R, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_B, OP_S, 7'h00, 7'h7F};

    i_rst_n = 0; i_dmem_rvalid = 0; i_dmem_rdata = '0;
    present(0, 7'h00, 3'd0, 5'd0, 32'h0, 32'h0, 0);
    model_reset();
    @(posedge i_clk); @(posedge i_clk); #1;
    compare_all("reset");
    i_rst_n = 1;

    present(1, OP_I, 3'd0, 5'd5, 32'h10, 32'h0, 1);
    tick("addi");
    check("addi_wen_k", 64'(or_wr_en), 64'd1);
    check("addi_data_k", 64'(or_rd_data), 64'h10);
    check("addi_instret_k", or_instret, 64'd1);
    $display("addi rd=5 -> wen=%0d data=%08h instret=%0d", or_wr_en, or_rd_data, or_instret);

    present(1, OP_JAL, 3'd0, 5'd1, 32'hDEAD_BEEF, 32'h100, 1);
    tick("jal");
    check("jal_data_k", 64'(or_rd_data), 64'h104);
    present(1, OP_JAL, 3'd0, 5'd0, 32'h0, 32'h200, 1);
    tick("jal_x0");
    check("jal_x0_wen_k", 64'(or_wr_en), 64'd0);
    check("jal_x0_instret_k", or_instret, 64'd3);
    $display("jal rd=0 -> wen=%0d instret=%0d", or_wr_en, or_instret);
    present(0, 7'h00, 3'd0, 5'd0, 32'h0, 32'h0, 0);

    do_load(3'd0, 5'd7, 32'h1003, 3, 32'h80FF_FFFF, stalls);
    check("lb_stalls", 64'(stalls), 64'd3);
    check("lb_data_k", 64'(or_rd_data), 64'hFFFF_FF80);
    do_load(3'd4, 5'd7, 32'h1003, 3, 32'h80FF_FFFF, stalls);
    check("lbu_data_k", 64'(or_rd_data), 64'h80);
    do_load(3'd1, 5'd7, 32'h1002, 1, 32'h1234_ABCD, stalls);
    check("lh_data_k", 64'(or_rd_data), 64'h1234);
    check("loads_instret_k", or_instret, 64'd6);

    // ADD held on the inputs while a load is outstanding.
    present(1, OP_L, 3'd2, 5'd8, 32'h40, 32'h0, 1);
    tick("hold_ld");
    present(1, OP_R, 3'd0, 5'd9, 32'h55, 32'h0, 1);
    rd9_writes = 0;
    tick("hold_w1");
    tick("hold_w2");
    i_dmem_rvalid = 1; i_dmem_rdata = 32'hCAFE_F00D;
    tick("hold_resp");
    check("hold_ld_data_k", 64'(or_rd_data), 64'hCAFE_F00D);
    i_dmem_rvalid = 0;
    tick("hold_add");
    if (or_wr_en && or_rd_addr == 5'd9) rd9_writes++;
    present(0, 7'h00, 3'd0, 5'd0, 32'h0, 32'h0, 0);
    tick("hold_after");
    if (or_wr_en && or_rd_addr == 5'd9) rd9_writes++;
    check("hold_add_once", 64'(rd9_writes), 64'd1);
    $display("held add -> rd9 writes=%0d instret=%0d", rd9_writes, or_instret);

    present(1, OP_S, 3'd2, 5'd3, 32'h80, 32'h0, 1);
    tick("store");
    check("store_instret_k", or_instret, 64'd9);
    present(1, OP_B, 3'd0, 5'd3, 32'h80, 32'h0, 1);
    tick("branch");
    check("branch_instret_k", or_instret, 64'd10);
    present(1, 7'h00, 3'd0, 5'd3, 32'h80, 32'h0, 1);
    tick("bubble");
    check("bubble_instret_k", or_instret, 64'd10);
    check("bubble_wen_k", 64'(or_wr_en), 64'd0);

    for (int n = 0; n < 1500; n++) begin
      if (!m_wait)
        present($urandom_range(0, 4) != 0, ops[$urandom_range(0, 11)], 3'($urandom_range(0, 7)),
                5'($urandom_range(0, 31)), $urandom, $urandom, $urandom_range(0, 3) != 0);
      i_dmem_rvalid = ($urandom_range(0, 2) == 0);
      i_dmem_rdata = $urandom;
      was_wait = m_wait;
      tick("rand");
      if (was_wait && !m_wait) $display("rand load done instret=%0d", or_instret);
    end
    i_dmem_rvalid = 0;

    // Reset while a load is outstanding.
    present(1, OP_L, 3'd2, 5'd4, 32'h0, 32'h0, 1);
    tick("rst_ld");
    present(0, 7'h00, 3'd0, 5'd0, 32'h0, 32'h0, 0);
    tick("rst_wait");
    i_rst_n = 0;
    model_reset();
    #1;
    compare_all("rst_async");
    @(posedge i_clk); #1;
    i_rst_n = 1;
    i_dmem_rvalid = 1; i_dmem_rdata = 32'h1111_2222;
    for (int n = 0; n < 3; n++) tick("rst_after");
    check("rst_instret_k", or_instret, 64'd0);
    check("rst_stall_k", 64'(o_stall), 64'd0);
    $display("reset mid-load -> wen=%0d instret=%0d stall=%0d", or_wr_en, or_instret, o_stall);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
